// File: rtl/sr194_rx_pkg.sv
// sr194_rx_pkg: shared FSM states, line levels and default frame width for the serial receiver
package sr194_rx_pkg;
  localparam int DATA_W = 4;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP = 1'b0;
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
endpackage

// File: rtl/sr194_rx_fifo.sv
// sr194_rx_fifo: synchronous circular buffer holding received {data, parity-error} entries
module sr194_rx_fifo #(
  parameter int W = 5,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         CR,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(D - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt_q == CW'(D);
  assign empty = cnt_q == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem_q[rp_q];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d = do_push ? inc(wp_q) : wp_q;
    rp_d = do_pop ? inc(rp_q) : rp_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!CR) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sr194_rx.sv
// sr194_rx: serial frame receiver (start, data MSB first, even parity, stop) feeding a small output buffer
module sr194_rx import sr194_rx_pkg::*; #(
  parameter int DATA_W = sr194_rx_pkg::DATA_W,
  parameter int FIFO_D = 2
) (
  input  logic clk,
  input  logic CR,
  input  logic SE,
  input  logic SI,
  input  logic READY,
  output logic QA,
  output logic QB,
  output logic QC,
  output logic QD,
  output logic PE,
  output logic VALID,
  output logic FE,
  output logic OVF
);
  localparam int CW = $clog2(DATA_W) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic par_q, par_d, fe_q, fe_d, ovf_q, ovf_d;
  logic push, pop, full, empty;
  logic [DATA_W:0] head;
  always_ff @(posedge clk) begin
    if (!CR) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = SE && SI == LINE_START ? DATA : IDLE;
      DATA:    state_d = SE && cnt_q == CW'(DATA_W - 1) ? PAR : DATA;
      PAR:     state_d = SE ? STOP : PAR;
      default: state_d = SE ? IDLE : STOP;
    endcase
  end
  always_comb begin
    cnt_d = cnt_q;
    sh_d = sh_q;
    par_d = par_q;
    if (SE && state_q == IDLE) begin
      cnt_d = '0;
      par_d = 1'b0;
    end else if (SE && state_q == DATA) begin
      cnt_d = cnt_q + 1'b1;
      sh_d = {sh_q[DATA_W-2:0], SI};
      par_d = par_q ^ SI;
    end else if (SE && state_q == PAR) begin
      par_d = par_q ^ SI;
    end
  end
  always_comb begin
    push = SE && state_q == STOP && SI == LINE_STOP;
    fe_d = SE && state_q == STOP && SI != LINE_STOP;
    pop = !empty && READY;
    ovf_d = ovf_q || (push && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (!CR) begin
      cnt_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      fe_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      par_q <= par_d;
      fe_q <= fe_d;
      ovf_q <= ovf_d;
    end
  end
  sr194_rx_fifo #(.W(DATA_W + 1), .D(FIFO_D)) u_fifo (
    .clk(clk),
    .CR(CR),
    .push(push),
    .pop(pop),
    .din({sh_q, par_q}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign {QD, QC, QB, QA} = head[DATA_W -: 4];
  assign PE = head[0];
  assign VALID = !empty;
  assign FE = fe_q;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_sr194_rx.sv
// tb_sr194_rx: table vectors, corner sequences and randomized traffic checked against a frame-level model
module tb_sr194_rx;
  logic clk = 1'b0;
  logic CR = 1'b0, SE = 1'b0, SI = 1'b0, READY = 1'b0;
  logic QA, QB, QC, QD, PE, VALID, FE, OVF;
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] d; logic pe;} ent_t;
  typedef struct {bit cr, se, si, rdy, v; logic [3:0] q; bit pe, fe, ovf, cq;} vec_t;
  ent_t mq[$];
  bit mfr[$];
  bit m_fe, m_ovf;
  vec_t tbl[$];
  always #5 clk = ~clk;
  sr194_rx #(.DATA_W(4), .FIFO_D(2)) dut (
    .clk(clk), .CR(CR), .SE(SE), .SI(SI), .READY(READY),
    .QA(QA), .QB(QB), .QC(QC), .QD(QD), .PE(PE),
    .VALID(VALID), .FE(FE), .OVF(OVF)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model(input bit cr, input bit se, input bit si, input bit rdy);
    bit push = 1'b0, pop, full;
    ent_t e = '{d: 4'h0, pe: 1'b0};
    m_fe = 1'b0;
    if (!cr) begin
      mfr.delete();
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    pop = mq.size() > 0 && rdy;
    full = mq.size() == 2;
    if (se && (mfr.size() > 0 || si)) begin
      mfr.push_back(si);
      if (mfr.size() == 7) begin
        for (int i = 0; i < 4; i++) e.d[3-i] = mfr[1+i];
        e.pe = ^e.d ^ mfr[5];
        if (mfr[6]) m_fe = 1'b1;
        else push = 1'b1;
        mfr.delete();
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) mq.push_back(e);
      else m_ovf = 1'b1;
    end
  endfunction
  task automatic step(input bit cr, input bit se, input bit si, input bit rdy);
    CR = cr; SE = se; SI = si; READY = rdy;
    @(posedge clk);
    model(cr, se, si, rdy);
    #1;
    chk("m_valid", VALID, mq.size() > 0);
    chk("m_fe", FE, m_fe);
    chk("m_ovf", OVF, m_ovf);
    if (mq.size() > 0) begin
      chk("m_data", {QD, QC, QB, QA}, mq[0].d);
      chk("m_pe", PE, mq[0].pe);
    end
  endtask
  function automatic void add(input bit cr, se, si, rdy, v, input logic [3:0] q, input bit pe, fe, ovf, cq);
    vec_t x;
    x.cr = cr; x.se = se; x.si = si; x.rdy = rdy; x.v = v;
    x.q = q; x.pe = pe; x.fe = fe; x.ovf = ovf; x.cq = cq;
    tbl.push_back(x);
  endfunction
  function automatic void add_frame(input logic [6:0] bits, input logic [3:0] q, input bit pe, input bit good);
    for (int i = 6; i >= 1; i--) add(1, 1, bits[i], 0, 0, 4'h0, 0, 0, 0, 0);
    if (good) add(1, 1, bits[0], 0, 1, q, pe, 0, 0, 1);
    else add(1, 1, bits[0], 0, 0, 4'h0, 0, 1, 0, 0);
  endfunction
  task automatic send_frame(input logic [3:0] d, input bit par_ok, input bit stop_ok, input bit rdy, input bit toggle);
    logic [6:0] bits;
    bits = {1'b1, d, (^d) ^ !par_ok, !stop_ok};
    for (int i = 6; i >= 0; i--) begin
      if (toggle) step(1, 0, 1'($urandom), rdy);
      step(1, 1, bits[i], rdy);
    end
  endtask
  initial begin
    add(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 1);
    add_frame(7'b1101000, 4'b1010, 0, 1);
    add(1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0);
    add_frame(7'b1111000, 4'b1110, 1, 1);
    add(1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0);
    add_frame(7'b1000111, 4'h0, 0, 0);
    add(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].cr, tbl[i].se, tbl[i].si, tbl[i].rdy);
      chk("tbl_valid", VALID, tbl[i].v);
      chk("tbl_fe", FE, tbl[i].fe);
      chk("tbl_ovf", OVF, tbl[i].ovf);
      if (tbl[i].cq) begin
        chk("tbl_data", {QD, QC, QB, QA}, tbl[i].q);
        chk("tbl_pe", PE, tbl[i].pe);
      end
    end
    step(0, 1, 1, 1);
    send_frame(4'h3, 1, 1, 0, 0);
    send_frame(4'h5, 1, 1, 0, 0);
    chk("ovf_before", OVF, 0);
    send_frame(4'h9, 1, 1, 0, 0);
    chk("ovf_set", OVF, 1);
    chk("ovf_head", {QD, QC, QB, QA}, 4'h3);
    step(1, 1, 0, 1);
    chk("pop1_valid", VALID, 1);
    chk("pop1_head", {QD, QC, QB, QA}, 4'h5);
    step(1, 1, 0, 1);
    chk("pop2_valid", VALID, 0);
    chk("ovf_sticky", OVF, 1);
    step(0, 1, 0, 0);
    send_frame(4'hA, 1, 1, 0, 1);
    chk("se_toggle_valid", VALID, 1);
    chk("se_toggle_data", {QD, QC, QB, QA}, 4'hA);
    chk("se_toggle_pe", PE, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 1);
    chk("midrst_valid", VALID, 0);
    send_frame(4'h6, 1, 1, 0, 0);
    chk("midrst_data", {QD, QC, QB, QA}, 4'h6);
    step(1, 1, 0, 1);
    chk("midrst_single", VALID, 0);
    step(0, 1, 0, 0);
    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
